// File: rtl/gyro_motion_tracker_if.sv
// Handshake bundle between the gyro SPI front end (master) and the motion tracker (slave).
// It carries the sample triple and the control pulses in, and the angles and tilt flags out.
interface gyro_motion_tracker_if #(
  parameter int ACC_W = 24
) ();
  logic                    sample_valid;
  logic signed [15:0]      x_axis_data;
  logic signed [15:0]      y_axis_data;
  logic signed [15:0]      z_axis_data;
  logic                    recalibrate;
  logic                    zero_angle;
  logic                    cal_done;
  logic                    out_valid;
  logic signed [ACC_W-1:0] x_angle;
  logic signed [ACC_W-1:0] y_angle;
  logic signed [ACC_W-1:0] z_angle;
  logic [2:0]              tilt_pos;
  logic [2:0]              tilt_neg;

  modport master (
    output sample_valid, x_axis_data, y_axis_data, z_axis_data, recalibrate, zero_angle,
    input  cal_done, out_valid, x_angle, y_angle, z_angle, tilt_pos, tilt_neg
  );

  modport slave (
    input  sample_valid, x_axis_data, y_axis_data, z_axis_data, recalibrate, zero_angle,
    output cal_done, out_valid, x_angle, y_angle, z_angle, tilt_pos, tilt_neg
  );
endinterface

// File: rtl/gyro_motion_tracker.sv
// Gyro rate integrator: learns per-axis bias over a startup window, then integrates
// dead-zoned, bias-corrected rates into saturating angles with hysteretic tilt flags.
module gyro_motion_tracker #(
  parameter int CAL_LOG2  = 4,
  parameter int DEAD_ZONE = 16,
  parameter int ACC_W     = 24,
  parameter int TILT_ON   = 20000,
  parameter int TILT_OFF  = 10000
) (
  input logic                  clk,
  input logic                  rst,
  gyro_motion_tracker_if.slave bus
);
  localparam int SUM_W = 16 + CAL_LOG2;
  localparam logic signed [ACC_W-1:0] ON_P  = ACC_W'(TILT_ON);
  localparam logic signed [ACC_W-1:0] OFF_P = ACC_W'(TILT_OFF);
  localparam logic signed [ACC_W-1:0] ON_N  = -ACC_W'(TILT_ON);
  localparam logic signed [ACC_W-1:0] OFF_N = -ACC_W'(TILT_OFF);

  typedef enum logic {ST_CAL, ST_RUN} state_t;

  state_t                  state;
  logic [CAL_LOG2-1:0]     cnt;
  logic signed [SUM_W-1:0] sum    [3];
  logic signed [SUM_W-1:0] sum_nx [3];
  logic signed [15:0]      bias   [3];
  logic signed [15:0]      smp    [3];
  logic signed [ACC_W-1:0] ang    [3];
  logic signed [ACC_W-1:0] ang_nx [3];
  logic [2:0]              tp, tn, tp_nx, tn_nx;
  logic                    cal_done_q, out_valid_q;

  assign smp[0] = bus.x_axis_data;
  assign smp[1] = bus.y_axis_data;
  assign smp[2] = bus.z_axis_data;

  assign bus.cal_done  = cal_done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.x_angle   = ang[0];
  assign bus.y_angle   = ang[1];
  assign bus.z_angle   = ang[2];
  assign bus.tilt_pos  = tp;
  assign bus.tilt_neg  = tn;

  // Bias-correct, dead-zone, then add with clamping instead of two's-complement wrap.
  function automatic logic signed [ACC_W-1:0] next_angle(
    input logic signed [ACC_W-1:0] a,
    input logic signed [15:0]      s,
    input logic signed [15:0]      b
  );
    logic signed [16:0]   d;
    logic [16:0]          mag;
    logic signed [ACC_W:0] acc;
    d   = {s[15], s} - {b[15], b};
    mag = d[16] ? 17'(-d) : 17'(d);
    if (mag <= 17'(DEAD_ZONE)) d = '0;
    acc = {a[ACC_W-1], a} + (ACC_W+1)'(d);
    if (acc[ACC_W] != acc[ACC_W-1])
      return acc[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return acc[ACC_W-1:0];
  endfunction

  always_comb begin
    // NOTE: defaults first so every path assigns every bit; otherwise a latch is inferred.
    tp_nx = tp;
    tn_nx = tn;
    for (int i = 0; i < 3; i++) begin
      sum_nx[i] = sum[i] + SUM_W'(smp[i]);
      ang_nx[i] = next_angle(ang[i], smp[i], bias[i]);
      if (ang_nx[i] >= ON_P)      tp_nx[i] = 1'b1;
      else if (ang_nx[i] < OFF_P) tp_nx[i] = 1'b0;
      if (ang_nx[i] <= ON_N)      tn_nx[i] = 1'b1;
      else if (ang_nx[i] > OFF_N) tn_nx[i] = 1'b0;
    end
  end

  // NOTE: sequential state uses <= only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the small sum/bias arrays are reset too; calibration must never resume from stale data.
      state       <= ST_CAL;
      cnt         <= '0;
      cal_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      tp          <= '0;
      tn          <= '0;
      for (int i = 0; i < 3; i++) begin
        sum[i]  <= '0;
        bias[i] <= '0;
        ang[i]  <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      if (bus.recalibrate) begin
        state      <= ST_CAL;
        cnt        <= '0;
        cal_done_q <= 1'b0;
        tp         <= '0;
        tn         <= '0;
        for (int i = 0; i < 3; i++) begin
          sum[i]  <= '0;
          bias[i] <= '0;
          ang[i]  <= '0;
        end
      end else begin
        case (state)
          ST_CAL: if (bus.sample_valid) begin
            if (cnt == '1) begin
              // Last sample of the window: latch floor average, leave it out of the angle.
              for (int i = 0; i < 3; i++) begin
                bias[i] <= 16'(sum_nx[i] >>> CAL_LOG2);
                sum[i]  <= '0;
              end
              cnt        <= '0;
              state      <= ST_RUN;
              cal_done_q <= 1'b1;
            end else begin
              for (int i = 0; i < 3; i++) sum[i] <= sum_nx[i];
              cnt <= cnt + 1'b1;
            end
          end
          ST_RUN: begin
            if (bus.zero_angle) begin
              for (int i = 0; i < 3; i++) ang[i] <= '0;
              tp          <= '0;
              tn          <= '0;
              out_valid_q <= 1'b1;
            end else if (bus.sample_valid) begin
              for (int i = 0; i < 3; i++) ang[i] <= ang_nx[i];
              tp          <= tp_nx;
              tn          <= tn_nx;
              out_valid_q <= 1'b1;
            end
          end
          default: state <= ST_CAL;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gyro_motion_tracker.sv
// Self-checking bench for gyro_motion_tracker: scoreboard of expected angle/flag updates,
// a vector table for the dead-zone cases, and directed sequences for the multi-cycle corners.
module tb_gyro_motion_tracker;
  localparam int ACC_W = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gyro_motion_tracker_if #(.ACC_W(ACC_W)) bus ();

  gyro_motion_tracker #(
    .CAL_LOG2(4), .DEAD_ZONE(16), .ACC_W(ACC_W), .TILT_ON(20000), .TILT_OFF(10000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic signed [ACC_W-1:0] x, y, z;
    logic [2:0]              tp, tn;
  } exp_t;

  typedef struct {
    logic signed [15:0] x, y, z;
    exp_t               e;
  } vec_t;

  exp_t sb[$];
  exp_t got;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input longint x, input longint y, input longint z,
                              input logic [2:0] tp, input logic [2:0] tn);
    exp_t e;
    e.x = ACC_W'(x); e.y = ACC_W'(y); e.z = ACC_W'(z);
    e.tp = tp; e.tn = tn;
    return e;
  endfunction

  // Every out_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected out_valid", 1, 0);
      end else begin
        got = sb.pop_front();
        check("x_angle",  bus.x_angle,  got.x);
        check("y_angle",  bus.y_angle,  got.y);
        check("z_angle",  bus.z_angle,  got.z);
        check("tilt_pos", bus.tilt_pos, got.tp);
        check("tilt_neg", bus.tilt_neg, got.tn);
      end
    end
  end

  task automatic drive(input logic signed [15:0] x, input logic signed [15:0] y,
                       input logic signed [15:0] z, input logic sv, input logic rc,
                       input logic za);
    @(posedge clk);
    #1;
    bus.x_axis_data = x; bus.y_axis_data = y; bus.z_axis_data = z;
    bus.sample_valid = sv; bus.recalibrate = rc; bus.zero_angle = za;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0; bus.recalibrate = 1'b0; bus.zero_angle = 1'b0;
  endtask

  task automatic run_sample(input logic signed [15:0] x, input logic signed [15:0] y,
                            input logic signed [15:0] z, input exp_t e);
    sb.push_back(e);
    drive(x, y, z, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic zero_all();
    sb.push_back(mk(0, 0, 0, 3'b000, 3'b000));
    drive(0, 0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check({name, " outstanding"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_cleared(input string name);
    check({name, " cal_done"},  bus.cal_done,  0);
    check({name, " out_valid"}, bus.out_valid, 0);
    check({name, " x_angle"},   bus.x_angle,   0);
    check({name, " y_angle"},   bus.y_angle,   0);
    check({name, " z_angle"},   bus.z_angle,   0);
    check({name, " tilt_pos"},  bus.tilt_pos,  0);
    check({name, " tilt_neg"},  bus.tilt_neg,  0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    // Bias (100,-3,0): edges of the dead zone (|d| = 16 and 17) plus large swings.
    tbl[0] = '{x: 16'sd110,  y: -16'sd3,    z: 16'sd0,    e: mk(0,    0,     0,   3'b000, 3'b000)};
    tbl[1] = '{x: 16'sd116,  y: -16'sd20,   z: 16'sd17,   e: mk(0,    -17,   17,  3'b000, 3'b000)};
    tbl[2] = '{x: 16'sd84,   y: 16'sd13,    z: -16'sd16,  e: mk(0,    -17,   17,  3'b000, 3'b000)};
    tbl[3] = '{x: 16'sd1100, y: -16'sd1003, z: 16'sd500,  e: mk(1000, -1017, 517, 3'b000, 3'b000)};
    tbl[4] = '{x: -16'sd900, y: -16'sd3,    z: -16'sd500, e: mk(0,    -1017, 17,  3'b000, 3'b000)};

    bus.sample_valid = 1'b0; bus.recalibrate = 1'b0; bus.zero_angle = 1'b0;
    bus.x_axis_data = '0; bus.y_axis_data = '0; bus.z_axis_data = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0;

    // Calibration window: bias (100,-3,0); cal_done only after the 16th sample.
    for (int i = 0; i < 15; i++) drive(100, -3, 0, 1'b1, 1'b0, 1'b0);
    check("cal_done after 15", bus.cal_done, 0);
    drive(100, -3, 0, 1'b1, 1'b0, 1'b0);
    check("cal_done after 16", bus.cal_done, 1);
    check("x_angle after cal", bus.x_angle, 0);

    // Inside the dead zone: five updates, angle stays 0.
    for (int i = 0; i < 5; i++) run_sample(110, -3, 0, mk(0, 0, 0, 3'b000, 3'b000));
    drain("dead zone");

    for (int i = 0; i < 5; i++) run_sample(tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].e);
    drain("table");

    // Positive tilt with hysteresis on X.
    zero_all();
    for (int i = 1; i <= 100; i++)
      run_sample(300, -3, 0, mk(200 * i, 0, 0, (200 * i >= 20000) ? 3'b001 : 3'b000, 3'b000));
    for (int j = 1; j <= 50; j++)
      run_sample(-100, -3, 0, mk(20000 - 200 * j, 0, 0, 3'b001, 3'b000));
    run_sample(-100, -3, 0, mk(9800, 0, 0, 3'b000, 3'b000));
    drain("tilt x");
    check("x_angle 9800", bus.x_angle, 9800);
    check("tilt_pos clear", bus.tilt_pos, 0);

    // Negative saturation on Y: -32765 per sample clamps, never wraps.
    zero_all();
    for (int k = 1; k <= 260; k++)
      run_sample(100, -32768, 0,
                 mk(0, (-32765 * k < -8388608) ? -8388608 : -32765 * k, 0, 3'b000, 3'b010));
    drain("y clamp");
    check("y_angle clamped", bus.y_angle, -8388608);

    // recalibrate wins over a simultaneous sample, which is not counted.
    drive(500, 500, 500, 1'b1, 1'b1, 1'b0);
    check_cleared("recal");
    for (int i = 0; i < 15; i++) drive((i < 8) ? -7 : -8, 3, -1000, 1'b1, 1'b0, 1'b0);
    check("recal cal_done after 15", bus.cal_done, 0);
    drive(-8, 3, -1000, 1'b1, 1'b0, 1'b0);
    check("recal cal_done after 16", bus.cal_done, 1);
    // Floor average -7.5 -> bias -8.
    run_sample(92, 3, -1000, mk(100, 0, 0, 3'b000, 3'b000));
    sb.push_back(mk(0, 0, 0, 3'b000, 3'b000));
    drive(1000, 3, -1000, 1'b1, 1'b0, 1'b1);
    run_sample(42, 20, -1000, mk(50, 17, 0, 3'b000, 3'b000));
    drain("zero_angle");

    // Reset while running clears everything.
    rst = 1'b1;
    #2;
    check_cleared("rst in run");
    rst = 1'b0;

    // Reset part-way through calibration: a full fresh window is needed.
    for (int i = 0; i < 7; i++) drive(1000, 1000, 1000, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    check_cleared("rst in cal");
    rst = 1'b0;
    for (int i = 0; i < 15; i++) drive(0, 0, 0, 1'b1, 1'b0, 1'b0);
    check("fresh cal_done after 15", bus.cal_done, 0);
    drive(0, 0, 0, 1'b1, 1'b0, 1'b0);
    check("fresh cal_done after 16", bus.cal_done, 1);
    run_sample(50, -50, 20, mk(50, -50, 20, 3'b000, 3'b000));
    drain("fresh bias");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
